// File: rtl/clkctl_pkg.sv
// Shared state encoding and defaults for the CPU clock/reset controller.
package clkctl_pkg;

  localparam logic [2:0] StateEncReset  = 3'd0;
  localparam logic [2:0] StateEncIdle   = 3'd1;
  localparam logic [2:0] StateEncRun    = 3'd2;
  localparam logic [2:0] StateEncStepHi = 3'd3;
  localparam logic [2:0] StateEncHalted = 3'd4;

  typedef enum logic [2:0] {
    StReset  = StateEncReset,
    StIdle   = StateEncIdle,
    StRun    = StateEncRun,
    StStepHi = StateEncStepHi,
    StHalted = StateEncHalted
  } clkctl_state_e;

  localparam int unsigned DefaultResetCycles = 8;

endpackage

// File: rtl/pulse_edge_detect.sv
// Rising-edge detector producing a one-cycle pulse. The history flop resets
// high so a level already asserted during reset never yields a pulse.
module pulse_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic pulse_o
);

  logic sig_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= 1'b1;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign pulse_o = sig_i & ~sig_q;

endmodule

// File: rtl/clock_reset_controller.sv
// Half-rate glitch-free CPU clock, stretched CPU reset, run/step/halt control
// and cycle counter. Optional cycle limit: CLOCK_RESET_CONTROLLER_CYCLE_LIMIT_EN.
module clock_reset_controller
  import clkctl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = DefaultResetCycles,
  parameter int unsigned COUNT_WIDTH  = 32
) (
  input  logic                   CLK,
  input  logic                   RST_bar,
  input  logic                   RUN,
  input  logic                   STEP,
  input  logic                   CPU_HALT,
`ifdef CLOCK_RESET_CONTROLLER_CYCLE_LIMIT_EN
  input  logic [COUNT_WIDTH-1:0] CYCLE_LIMIT,
  input  logic                   LIMIT_ENABLE,
  output logic                   LIMIT_HIT,
`endif
  output logic                   CPU_CLK,
  output logic                   CPU_RST_bar,
  output logic                   RUNNING,
  output logic                   HALTED,
  output logic [COUNT_WIDTH-1:0] CYCLE_COUNT
);

  localparam int unsigned RstCntW = $clog2(RESET_CYCLES + 1);
  localparam logic [RstCntW-1:0] RstCntMax = RstCntW'(RESET_CYCLES);

  clkctl_state_e          state_q, state_d;
  logic                   cpu_clk_q, cpu_clk_d;
  logic                   cpu_rst_n_q, cpu_rst_n_d;
  logic [RstCntW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [COUNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic                   running_q, running_d;
  logic                   halted_q, halted_d;
  logic                   step_req;
  logic                   run_ok;

  pulse_edge_detect u_step_edge (
    .clk_i   (CLK),
    .rst_ni  (RST_bar),
    .sig_i   (STEP),
    .pulse_o (step_req)
  );

`ifdef CLOCK_RESET_CONTROLLER_CYCLE_LIMIT_EN
  logic limit_hit_q, limit_hit_d;
  // Set when a limit stops the run; RUN must be seen low before restarting.
  logic run_block_q, run_block_d;
  assign run_ok = ~run_block_q;
`else
  assign run_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    cpu_clk_d   = cpu_clk_q;
    cpu_rst_n_d = cpu_rst_n_q;
    rst_cnt_d   = rst_cnt_q;
`ifdef CLOCK_RESET_CONTROLLER_CYCLE_LIMIT_EN
    limit_hit_d = 1'b0;
    run_block_d = run_block_q;
`endif
    unique case (state_q)
      StReset: begin
        if (cpu_clk_q && (rst_cnt_q == RstCntMax)) begin
          cpu_clk_d   = 1'b0;
          cpu_rst_n_d = 1'b1;
          state_d     = StIdle;
        end else begin
          cpu_clk_d = ~cpu_clk_q;
          if (!cpu_clk_q) begin
            rst_cnt_d = rst_cnt_q + RstCntW'(1);
          end
        end
      end
      StIdle: begin
`ifdef CLOCK_RESET_CONTROLLER_CYCLE_LIMIT_EN
        if (!RUN) begin
          run_block_d = 1'b0;
        end
`endif
        if (CPU_HALT) begin
          state_d = StHalted;
        end else if (RUN && run_ok) begin
          state_d   = StRun;
          cpu_clk_d = 1'b1;
        end else if (step_req) begin
          state_d   = StStepHi;
          cpu_clk_d = 1'b1;
        end
      end
      StRun: begin
        if (cpu_clk_q) begin
          cpu_clk_d = 1'b0;
        end else if (CPU_HALT) begin
          state_d = StHalted;
        end
`ifdef CLOCK_RESET_CONTROLLER_CYCLE_LIMIT_EN
        else if (LIMIT_ENABLE && (cycle_cnt_q == CYCLE_LIMIT)) begin
          state_d     = StIdle;
          limit_hit_d = 1'b1;
          run_block_d = 1'b1;
        end
`endif
        else if (!RUN) begin
          state_d = StIdle;
        end else begin
          cpu_clk_d = 1'b1;
        end
      end
      StStepHi: begin
        cpu_clk_d = 1'b0;
        state_d   = StIdle;
      end
      StHalted: begin
        cpu_clk_d = 1'b0;
      end
      default: begin
        cpu_clk_d = 1'b0;
        state_d   = StReset;
      end
    endcase
  end

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if ((state_q != StReset) && cpu_clk_d && !cpu_clk_q) begin
      cycle_cnt_d = cycle_cnt_q + COUNT_WIDTH'(1);
    end
    running_d = (state_d == StRun);
    halted_d  = (state_d == StHalted);
  end

  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      state_q     <= StReset;
      cpu_clk_q   <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      rst_cnt_q   <= '0;
      cycle_cnt_q <= '0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_clk_q   <= cpu_clk_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      rst_cnt_q   <= rst_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
    end
  end

`ifdef CLOCK_RESET_CONTROLLER_CYCLE_LIMIT_EN
  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      limit_hit_q <= 1'b0;
      run_block_q <= 1'b0;
    end else begin
      limit_hit_q <= limit_hit_d;
      run_block_q <= run_block_d;
    end
  end

  assign LIMIT_HIT = limit_hit_q;
`endif

  assign CPU_CLK     = cpu_clk_q;
  assign CPU_RST_bar = cpu_rst_n_q;
  assign RUNNING     = running_q;
  assign HALTED      = halted_q;
  assign CYCLE_COUNT = cycle_cnt_q;

endmodule

// File: tb/tb_clock_reset_controller.sv
// Directed bench for clock_reset_controller; limit scenario built only when
// CLOCK_RESET_CONTROLLER_CYCLE_LIMIT_EN is defined.
module tb_clock_reset_controller;

  logic        CLK = 1'b0;
  logic        RST_bar = 1'b1;
  logic        RUN = 1'b0;
  logic        STEP = 1'b0;
  logic        CPU_HALT = 1'b0;
  logic        CPU_CLK;
  logic        CPU_RST_bar;
  logic        RUNNING;
  logic        HALTED;
  logic [31:0] CYCLE_COUNT;
`ifdef CLOCK_RESET_CONTROLLER_CYCLE_LIMIT_EN
  logic [31:0] CYCLE_LIMIT = 32'd0;
  logic        LIMIT_ENABLE = 1'b0;
  logic        LIMIT_HIT;
`endif

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  clock_reset_controller #(
    .RESET_CYCLES (8),
    .COUNT_WIDTH  (32)
  ) dut (
    .CLK          (CLK),
    .RST_bar      (RST_bar),
    .RUN          (RUN),
    .STEP         (STEP),
    .CPU_HALT     (CPU_HALT),
`ifdef CLOCK_RESET_CONTROLLER_CYCLE_LIMIT_EN
    .CYCLE_LIMIT  (CYCLE_LIMIT),
    .LIMIT_ENABLE (LIMIT_ENABLE),
    .LIMIT_HIT    (LIMIT_HIT),
`endif
    .CPU_CLK      (CPU_CLK),
    .CPU_RST_bar  (CPU_RST_bar),
    .RUNNING      (RUNNING),
    .HALTED       (HALTED),
    .CYCLE_COUNT  (CYCLE_COUNT)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs n edges and returns how many CPU_CLK rising transitions were seen.
  task automatic run_edges(input int n, output int pulses);
    logic prev;
    pulses = 0;
    prev = CPU_CLK;
    for (int i = 0; i < n; i++) begin
      tick();
      if (!prev && CPU_CLK) pulses++;
      prev = CPU_CLK;
    end
  endtask

  task automatic test_reset();
    int pulses;
    logic early;
    STEP = 1'b1;  // held through reset: must not produce a step pulse
    #2 RST_bar = 1'b0;
    #1;
    tests++;
    if ({CPU_CLK, CPU_RST_bar, RUNNING, HALTED} !== 4'b0000 || CYCLE_COUNT !== 32'd0) begin
      fails++;
      $display("FAIL reset_values: clk=%b rstb=%b run=%b halt=%b cnt=%0d, want all 0",
               CPU_CLK, CPU_RST_bar, RUNNING, HALTED, CYCLE_COUNT);
    end
    tick();
    tick();
    RST_bar = 1'b1;
    early = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      logic prev;
      prev = CPU_CLK;
      tick();
      if (!prev && CPU_CLK) pulses++;
      if (i < 16 && CPU_RST_bar) early = 1'b1;
    end
    tests++;
    if (pulses !== 8) begin
      fails++;
      $display("FAIL reset_pulses: got %0d want 8", pulses);
    end
    tests++;
    if (early !== 1'b0) begin
      fails++;
      $display("FAIL reset_early_release: CPU_RST_bar rose before edge 16");
    end
    tests++;
    if (CPU_RST_bar !== 1'b1 || CPU_CLK !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_edge16: rstb=%b clk=%b want 1/0", CPU_RST_bar, CPU_CLK);
    end
    run_edges(4, pulses);
    tests++;
    if (pulses !== 0 || CYCLE_COUNT !== 32'd0 || RUNNING !== 1'b0) begin
      fails++;
      $display("FAIL reset_step_held: pulses=%0d cnt=%0d running=%b want 0/0/0",
               pulses, CYCLE_COUNT, RUNNING);
    end
    STEP = 1'b0;
    tick();
  endtask

  task automatic test_step();
    int pulses;
    logic c1, c2;
    STEP = 1'b1;
    tick();
    c1 = CPU_CLK;
    tick();
    c2 = CPU_CLK;
    run_edges(8, pulses);
    tests++;
    if (c1 !== 1'b1 || c2 !== 1'b0 || pulses !== 0) begin
      fails++;
      $display("FAIL step_single_pulse: hi=%b lo=%b extra=%0d want 1/0/0", c1, c2, pulses);
    end
    tests++;
    if (CYCLE_COUNT !== 32'd1) begin
      fails++;
      $display("FAIL step_count1: got %0d want 1", CYCLE_COUNT);
    end
    STEP = 1'b0;
    tick();
    STEP = 1'b1;
    run_edges(4, pulses);
    STEP = 1'b0;
    tests++;
    if (CYCLE_COUNT !== 32'd2 || pulses !== 1 || CPU_CLK !== 1'b0) begin
      fails++;
      $display("FAIL step_count2: cnt=%0d pulses=%0d clk=%b want 2/1/0",
               CYCLE_COUNT, pulses, CPU_CLK);
    end
  endtask

  task automatic test_run();
    int pulses;
    logic r1;
    RUN = 1'b1;
    tick();
    r1 = RUNNING;
    run_edges(19, pulses);
    pulses++;  // first pulse rose on the initial edge
    RUN = 1'b0;
    tick();
    tests++;
    if (r1 !== 1'b1) begin
      fails++;
      $display("FAIL run_running: got %b want 1", r1);
    end
    tests++;
    if (pulses !== 10 || CYCLE_COUNT !== 32'd12) begin
      fails++;
      $display("FAIL run_pulses: pulses=%0d cnt=%0d want 10/12", pulses, CYCLE_COUNT);
    end
    tests++;
    if (RUNNING !== 1'b0 || CPU_CLK !== 1'b0) begin
      fails++;
      $display("FAIL run_stop_park: running=%b clk=%b want 0/0", RUNNING, CPU_CLK);
    end
  endtask

  task automatic test_halt();
    int pulses;
    int bad;
    RUN = 1'b1;
    run_edges(10, pulses);
    CPU_HALT = 1'b1;
    run_edges(10, pulses);
    tests++;
    if (pulses !== 0 || HALTED !== 1'b1 || RUNNING !== 1'b0) begin
      fails++;
      $display("FAIL halt_enter: pulses=%0d halted=%b running=%b want 0/1/0",
               pulses, HALTED, RUNNING);
    end
    tests++;
    if (CYCLE_COUNT !== 32'd17) begin
      fails++;
      $display("FAIL halt_count: got %0d want 17", CYCLE_COUNT);
    end
    CPU_HALT = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      RUN  = i[0];
      STEP = ~i[0];
      tick();
      if (CPU_CLK !== 1'b0) bad++;
    end
    RUN = 1'b0;
    STEP = 1'b0;
    tick();
    tests++;
    if (bad !== 0 || HALTED !== 1'b1 || CYCLE_COUNT !== 32'd17) begin
      fails++;
      $display("FAIL halt_sticky: clk_high=%0d halted=%b cnt=%0d want 0/1/17",
               bad, HALTED, CYCLE_COUNT);
    end
  endtask

  task automatic test_midrun_reset();
    int pulses;
    RST_bar = 1'b0;
    #1;
    RST_bar = 1'b1;
    run_edges(16, pulses);
    RUN = 1'b1;
    tick();
    tests++;
    if (CPU_CLK !== 1'b1 || CYCLE_COUNT !== 32'd1) begin
      fails++;
      $display("FAIL midrun_start: clk=%b cnt=%0d want 1/1", CPU_CLK, CYCLE_COUNT);
    end
    RST_bar = 1'b0;
    #1;
    tests++;
    if (CPU_CLK !== 1'b0 || CPU_RST_bar !== 1'b0 || CYCLE_COUNT !== 32'd0) begin
      fails++;
      $display("FAIL midrun_async: clk=%b rstb=%b cnt=%0d want 0/0/0",
               CPU_CLK, CPU_RST_bar, CYCLE_COUNT);
    end
    RUN = 1'b0;
    tick();
    RST_bar = 1'b1;
    run_edges(15, pulses);
    tests++;
    if (CPU_RST_bar !== 1'b0) begin
      fails++;
      $display("FAIL midrun_edge15: rstb=%b want 0", CPU_RST_bar);
    end
    tick();
    tests++;
    if (pulses !== 8 || CPU_RST_bar !== 1'b1 || CPU_CLK !== 1'b0 || CYCLE_COUNT !== 32'd0) begin
      fails++;
      $display("FAIL midrun_restretch: pulses=%0d rstb=%b clk=%b cnt=%0d want 8/1/0/0",
               pulses, CPU_RST_bar, CPU_CLK, CYCLE_COUNT);
    end
  endtask

  task automatic test_halt_while_high();
    RUN = 1'b1;
    tick();
    CPU_HALT = 1'b1;
    tick();
    tests++;
    if (CPU_CLK !== 1'b0 || RUNNING !== 1'b1 || HALTED !== 1'b0) begin
      fails++;
      $display("FAIL halt_high_ignored: clk=%b running=%b halted=%b want 0/1/0",
               CPU_CLK, RUNNING, HALTED);
    end
    tick();
    tests++;
    if (HALTED !== 1'b1 || CPU_CLK !== 1'b0 || CYCLE_COUNT !== 32'd1) begin
      fails++;
      $display("FAIL halt_high_decision: halted=%b clk=%b cnt=%0d want 1/0/1",
               HALTED, CPU_CLK, CYCLE_COUNT);
    end
    CPU_HALT = 1'b0;
    RUN = 1'b0;
  endtask

`ifdef CLOCK_RESET_CONTROLLER_CYCLE_LIMIT_EN
  task automatic test_limit();
    int pulses;
    int hits;
    int hit_at;
    logic prev;
    RST_bar = 1'b0;
    #1;
    RST_bar = 1'b1;
    run_edges(16, pulses);
    CYCLE_LIMIT = 32'd3;
    LIMIT_ENABLE = 1'b1;
    RUN = 1'b1;
    pulses = 0;
    hits = 0;
    hit_at = 0;
    prev = CPU_CLK;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (!prev && CPU_CLK) pulses++;
      if (LIMIT_HIT) begin
        hits++;
        hit_at = i;
      end
      prev = CPU_CLK;
    end
    tests++;
    if (pulses !== 3 || CYCLE_COUNT !== 32'd3) begin
      fails++;
      $display("FAIL limit_pulses: pulses=%0d cnt=%0d want 3/3", pulses, CYCLE_COUNT);
    end
    tests++;
    if (hits !== 1 || hit_at !== 7) begin
      fails++;
      $display("FAIL limit_hit_pulse: hits=%0d at=%0d want 1 at 7", hits, hit_at);
    end
    tests++;
    if (RUNNING !== 1'b0 || HALTED !== 1'b0 || CPU_CLK !== 1'b0) begin
      fails++;
      $display("FAIL limit_idle: running=%b halted=%b clk=%b want 0/0/0",
               RUNNING, HALTED, CPU_CLK);
    end
    RUN = 1'b0;
    tick();
    RUN = 1'b1;
    tick();
    tests++;
    if (CPU_CLK !== 1'b1 || RUNNING !== 1'b1) begin
      fails++;
      $display("FAIL limit_restart: clk=%b running=%b want 1/1", CPU_CLK, RUNNING);
    end
    RUN = 1'b0;
    LIMIT_ENABLE = 1'b0;
    tick();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_step();
    test_run();
    test_halt();
    test_midrun_reset();
    test_halt_while_high();
`ifdef CLOCK_RESET_CONTROLLER_CYCLE_LIMIT_EN
    test_limit();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clock_reset_controller.md
Name: clock_reset_controller

Overview:
- Sits directly upstream of the processor top level and drives its CLK and RST_bar.
- Derives a glitch-free, half-rate CPU clock from the board clock and generates a stretched CPU reset, clocked throughout so the pipeline and PC flush.
- Provides run, single-step and halt control, and counts executed CPU cycles.
- Consumes the processor's HALT output to freeze the CPU clock.

Parameters:
- RESET_CYCLES, 8: number of full CPU_CLK periods issued while CPU_RST_bar is low (must be >= 1).
- COUNT_WIDTH, 32: width of CYCLE_COUNT.

Ports:
- CLK  input  1  board clock; all state changes on its rising edge.
- RST_bar  input  1  reset, asynchronous, active-low.
- RUN  input  1  level; free-run the CPU while high.
- STEP  input  1  synchronous; each rising edge requests one CPU clock pulse.
- CPU_HALT  input  1  processor HALT output.
- CPU_CLK  output  1  registered clock to the processor's CLK.
- CPU_RST_bar  output  1  registered reset to the processor's RST_bar.
- RUNNING  output  1  high in RUN state.
- HALTED  output  1  high in HALTED state.
- CYCLE_COUNT  output  COUNT_WIDTH  count of CPU_CLK rising transitions with CPU_RST_bar high.

Behaviour:
- Async reset (RST_bar low):
  - CPU_CLK=0, CPU_RST_bar=0, RUNNING=0, HALTED=0, CYCLE_COUNT=0.
  - Reset-period counter=0, STEP edge-detect history=1, state=RESET.
  - Mid-operation reset may truncate a CPU_CLK high phase; this is accepted.
- All outputs are registered. CPU_CLK toggles at most once per CLK edge, so it is glitch-free with period 2 CLK.
- Decision point: a CLK edge at which CPU_CLK==0. State changes that stop or start the clock happen only there, so CPU_CLK always parks low.
- States:
  - RESET: CPU_CLK toggles every edge and the counter increments on each 0->1.
    - When counter==RESET_CYCLES and CPU_CLK==1, the next edge sets CPU_CLK=0 and CPU_RST_bar=1 together, then goes to IDLE.
    - So CPU_RST_bar rises on the 2*RESET_CYCLES-th CLK edge after RST_bar release.
  - IDLE: CPU_CLK held 0. Priority at the decision point: CPU_HALT=1 -> HALTED; else RUN=1 -> RUN (CPU_CLK->1 on the same edge); else step_req -> STEP_HI (CPU_CLK->1).
  - RUN: CPU_CLK toggles. At each decision point:
    - CPU_HALT=1 -> HALTED, no further pulse.
    - else RUN=0 -> IDLE.
    - else CPU_CLK->1.
    - RUN falling while CPU_CLK=1 completes the low transition first.
  - STEP_HI: CPU_CLK->0 on the next edge, then IDLE. Exactly one pulse.
  - HALTED: CPU_CLK held 0. Exits only via RST_bar.
- step_req = STEP & ~STEP_prev.
  - Requests arriving outside IDLE are dropped, not queued.
  - Holding STEP high yields a single pulse.
- CYCLE_COUNT increments on every CPU_CLK 0->1 transition outside RESET. Wraps modulo 2^COUNT_WIDTH.
- CPU_HALT is sampled only at decision points, so it is ignored while CPU_CLK is high.

Optional Feature:
- Macro CLOCK_RESET_CONTROLLER_CYCLE_LIMIT_EN.
- When defined, adds:
  - input CYCLE_LIMIT [COUNT_WIDTH]
  - input LIMIT_ENABLE [1]
  - output LIMIT_HIT [1]
- In RUN at a decision point with LIMIT_ENABLE=1 and CYCLE_COUNT==CYCLE_LIMIT: go to IDLE and pulse LIMIT_HIT high for exactly one CLK cycle.
  - CPU_HALT keeps priority over the limit.
  - RUN held high does not restart until RUN has been seen low at one decision point.
- LIMIT_HIT resets to 0.
- When undefined, these ports and all limit logic are absent and behaviour is unchanged.

Decomposition:
- Package clkctl_pkg holds:
  - the state enum: RESET, IDLE, RUN, STEP_HI, HALTED.
  - the 3-bit state encoding constants.
  - the default RESET_CYCLES constant.
- Sub-module pulse_edge_detect: registers STEP and outputs the one-cycle step_req. Its history flop resets to 1, so STEP held high through reset never produces a pulse.

Test Plan:
- Reset stretch, RESET_CYCLES=8, RST_bar released at t0 -> 8 CPU_CLK pulses; CPU_RST_bar rises on edge 16 with CPU_CLK=0; state IDLE; CYCLE_COUNT=0.
- Single step: STEP high for 10 CLK cycles in IDLE -> exactly one CPU_CLK pulse (high 1 CLK, low after); CYCLE_COUNT=1; second STEP edge -> CYCLE_COUNT=2.
- Run and stop: RUN high for 20 CLK edges then low -> 10 CPU_CLK pulses; CYCLE_COUNT=10; RUNNING low; CPU_CLK parked 0.
- Halt: RUN held high, CPU_HALT driven high after 5th pulse's falling edge -> no 6th pulse; HALTED=1; RUN toggling and STEP edges have no effect until RST_bar pulse.
- Mid-run reset: RST_bar low while CPU_CLK=1 -> CPU_CLK, CPU_RST_bar, CYCLE_COUNT go 0 asynchronously; full reset stretch repeats after release.
- With macro, CYCLE_LIMIT=3, LIMIT_ENABLE=1 -> RUN stops after 3 pulses; LIMIT_HIT high exactly one CLK cycle; state IDLE.
